// File: rtl/vga_wave_pkg.sv
// Shared constants, colour encodings and capture-state type for the oscilloscope pixel source.
package vga_wave_pkg;

    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned AXIS_ROW   = 239;
    localparam int unsigned TRACE_BASE = 367;

    localparam int unsigned SAMPLE_W  = 8;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned COL_W     = 10;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned RAM_DEPTH = 2 * H_ACTIVE;

    localparam logic [SAMPLE_W-1:0] ZERO_LEVEL = 8'd128;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};
    localparam rgb_t RGB_TRACE = '{r: 3'd0, g: 3'd7, b: 2'd0};
    localparam rgb_t RGB_AXIS  = '{r: 3'd0, g: 3'd0, b: 2'd3};
    localparam rgb_t RGB_GRID  = '{r: 3'd2, g: 3'd0, b: 2'd0};

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    // Banks are packed back to back: bank 1 starts right after the 640 columns of bank 0.
    function automatic logic [ADDR_W-1:0] ram_addr(input logic bank, input logic [COL_W-1:0] col);
        return bank ? (ADDR_W'(col) + ADDR_W'(H_ACTIVE)) : ADDR_W'(col);
    endfunction

endpackage

// File: rtl/wave_column_ram.sv
// Simple dual-port column memory: one write port, one registered read port.
module wave_column_ram
    import vga_wave_pkg::*;
#(
    parameter int unsigned DEPTH = RAM_DEPTH,
    parameter int unsigned AW    = ADDR_W,
    parameter int unsigned DW    = SAMPLE_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wave_pixel_source.sv
// Triggered 640-sample capture into a double-buffered column RAM, rendered as an
// oscilloscope trace with axis and grid for the VGA controller (2-cycle pixel latency).
module wave_pixel_source
    import vga_wave_pkg::*;
#(
    parameter int unsigned DECIM        = 4,
    parameter int unsigned TRIG_TIMEOUT = 2048,
    parameter int unsigned GRID_SPACING = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                frame_start,
    input  logic [COORD_W-1:0]  pixel_x,
    input  logic [COORD_W-1:0]  pixel_y,
    input  logic                pixel_req,
    output logic [2:0]          red,
    output logic [2:0]          green,
    output logic [1:0]          blue
);

    localparam int unsigned DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned TO_W = $clog2(TRIG_TIMEOUT + 1);

    localparam logic [DC_W-1:0]    DC_LAST   = DC_W'(DECIM - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TRIG_TIMEOUT - 1);
    localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] GRID_MASK = COORD_W'(GRID_SPACING - 1);

    cap_state_e state;
    cap_state_e state_nxt;

    logic [DC_W-1:0]     dc;
    logic [COL_W-1:0]    col;
    logic [SAMPLE_W-1:0] prev;
    logic [TO_W-1:0]     tcnt;
    logic                wbank;
    logic                disp_valid;

    logic                transfer;
    logic                keep;
    logic                trig;
    logic                swap;
    logic                we;
    logic [COL_W-1:0]    wcol;

    assign sample_ready = !rst && (state != ST_DONE);
    assign transfer     = sample_valid && sample_ready;
    assign keep         = transfer && (dc == '0);
    // Rising crossing of the zero level, or the TRIG_TIMEOUT-th kept sample while armed.
    assign trig         = ((prev < ZERO_LEVEL) && (sample_in >= ZERO_LEVEL)) || (tcnt == TO_LAST);
    assign swap         = (state == ST_DONE) && frame_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ARM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        wcol      = col;
        case (state)
            ST_ARM: begin
                if (keep && trig) begin
                    state_nxt = ST_CAPTURE;
                    we        = 1'b1;
                    wcol      = '0;
                end
            end
            ST_CAPTURE: begin
                if (keep) begin
                    we = 1'b1;
                    if (col == COL_LAST) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (frame_start) begin
                    state_nxt = ST_ARM;
                end
            end
            default: state_nxt = ST_ARM;
        endcase
    end

    // Capture datapath: decimation, trigger history, column pointer and bank ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc         <= '0;
            col        <= '0;
            prev       <= '0;
            tcnt       <= '0;
            wbank      <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            if (swap) begin
                dc <= '0;
            end else if (transfer) begin
                dc <= (dc == DC_LAST) ? '0 : dc + DC_W'(1);
            end

            if (keep) begin
                prev <= sample_in;
            end

            if (swap) begin
                wbank      <= ~wbank;
                disp_valid <= 1'b1;
                tcnt       <= '0;
                col        <= '0;
            end

            if ((state == ST_ARM) && keep) begin
                if (trig) begin
                    tcnt <= '0;
                    col  <= COL_W'(1);
                end else begin
                    tcnt <= tcnt + TO_W'(1);
                end
            end

            if ((state == ST_CAPTURE) && keep) begin
                col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
            end
        end
    end

    logic [COL_W-1:0]    rcol;
    logic [SAMPLE_W-1:0] rdata;

    assign rcol = (pixel_x < COORD_W'(H_ACTIVE)) ? pixel_x : '0;

    wave_column_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ram_addr(wbank, wcol)),
        .wdata (sample_in),
        .raddr (ram_addr(~wbank, rcol)),
        .rdata (rdata)
    );

    // Stage 1: coordinates travel alongside the registered RAM read.
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               req1;
    logic               dv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            x1   <= '0;
            y1   <= '0;
            req1 <= 1'b0;
            dv1  <= 1'b0;
        end else begin
            x1   <= pixel_x;
            y1   <= pixel_y;
            req1 <= pixel_req;
            dv1  <= disp_valid;
        end
    end

    // Stage 2: priority colour select (trace > axis > grid > black).
    logic [COORD_W-1:0] row;
    logic               in_range;
    rgb_t               pix;
    rgb_t               colour_q;

    assign row      = COORD_W'(TRACE_BASE) - COORD_W'(rdata);
    assign in_range = req1 && (x1 < COORD_W'(H_ACTIVE)) && (y1 < COORD_W'(V_ACTIVE));

    always_comb begin
        pix = RGB_BLACK;
        if (in_range) begin
            if (dv1 && (y1 == row)) begin
                pix = RGB_TRACE;
            end else if (y1 == COORD_W'(AXIS_ROW)) begin
                pix = RGB_AXIS;
            end else if ((x1 & GRID_MASK) == '0) begin
                pix = RGB_GRID;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colour_q <= RGB_BLACK;
        end else begin
            colour_q <= pix;
        end
    end

    assign red   = colour_q.r;
    assign green = colour_q.g;
    assign blue  = colour_q.b;

endmodule

// File: tb/tb_wave_pixel_source.sv
// Randomised directed bench for wave_pixel_source: two instances (DECIM 1 and 4) checked
// against a window/colour model derived from the capture and rendering rules.
module tb_wave_pixel_source;

    localparam int TIMEOUT = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       pixel_req = 1'b0;
    logic       sel = 1'b0;

    logic       ready1, ready4;
    logic [2:0] r1, g1, r4, g4;
    logic [1:0] b1, b4;

    wire        valid1 = sample_valid && !sel;
    wire        valid4 = sample_valid && sel;
    wire        ready  = sel ? ready4 : ready1;
    wire  [7:0] colour = sel ? {r4, g4, b4} : {r1, g1, b1};

    always #5 clk = ~clk;

    wave_pixel_source #(.DECIM(1), .TRIG_TIMEOUT(TIMEOUT), .GRID_SPACING(64)) u_d1 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(valid1),
        .sample_ready(ready1), .frame_start(frame_start), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .pixel_req(pixel_req), .red(r1), .green(g1), .blue(b1)
    );

    wave_pixel_source #(.DECIM(4), .TRIG_TIMEOUT(TIMEOUT), .GRID_SPACING(64)) u_d4 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(valid4),
        .sample_ready(ready4), .frame_start(frame_start), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .pixel_req(pixel_req), .red(r4), .green(g4), .blue(b4)
    );

    int total = 0;
    int bad   = 0;

    // Model: every accepted sample since the last swap/reset, plus the displayed window.
    int q[$];
    int prev0;
    bit mv;
    int disp[640];
    int win[640];
    int win_n;
    int last_kept;
    int cur_decim = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void eval_win();
        int p = prev0;
        int t = 0;
        bit cap = 0;
        win_n = 0;
        for (int i = 0; i < q.size(); i += cur_decim) begin
            int s = q[i];
            if (!cap) begin
                t++;
                if ((p < 128 && s >= 128) || t == TIMEOUT) begin
                    cap = 1;
                    win[0] = s;
                    win_n = 1;
                end
            end else if (win_n < 640) begin
                win[win_n] = s;
                win_n++;
            end
            p = s;
        end
        last_kept = p;
    endfunction

    function automatic logic [7:0] colour_of(input int x, input int y);
        if (x >= 640 || y >= 480) return 8'h00;
        if (mv && y == 367 - disp[x]) return 8'h1C;
        if (y == 239) return 8'h03;
        if (x % 64 == 0) return 8'h40;
        return 8'h00;
    endfunction

    task automatic model_reset();
        q.delete();
        prev0 = 0;
        mv    = 0;
        win_n = 0;
    endtask

    task automatic apply_swap();
        eval_win();
        for (int i = 0; i < 640; i++) disp[i] = win[i];
        mv    = 1;
        prev0 = last_kept;
        q.delete();
        eval_win();
    endtask

    task automatic send(input int s, input bit fs);
        bit exp_rdy;
        bit do_swap;
        eval_win();
        exp_rdy = (win_n < 640);
        do_swap = fs && !exp_rdy;
        sample_in    = 8'(s);
        sample_valid = 1'b1;
        frame_start  = fs;
        #1;
        chk("sample_ready", 32'(ready), 32'(exp_rdy));
        @(negedge clk);
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        if (exp_rdy) q.push_back(s);
        if (do_swap) apply_swap();
        eval_win();
    endtask

    task automatic frame();
        bit do_swap;
        eval_win();
        do_swap = (win_n == 640);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (do_swap) apply_swap();
    endtask

    task automatic pix_req(input int x, input int y, input bit req);
        logic [7:0] exp;
        exp = req ? colour_of(x, y) : 8'h00;
        pixel_x   = 10'(x);
        pixel_y   = 10'(y);
        pixel_req = req;
        @(negedge clk);
        pixel_req = 1'b0;
        @(negedge clk);
        chk($sformatf("pixel(%0d,%0d,req=%0d)", x, y, req), 32'(colour), 32'(exp));
    endtask

    task automatic pix(input int x, input int y);
        pix_req(x, y, 1'b1);
    endtask

    task automatic random_pixels(input int n);
        for (int j = 0; j < n; j++) begin
            int x = $urandom_range(0, 639);
            int y = ($urandom_range(0, 1) == 1) ? 367 - disp[x] : $urandom_range(0, 520);
            pix(x, y);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("ready_in_reset", 32'(ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("colour_after_reset_c1", 32'(colour), 32'd0);
        @(negedge clk);
        chk("colour_after_reset_c2", 32'(colour), 32'd0);
    endtask

    initial begin
        bit seen;
        model_reset();
        @(negedge clk);
        do_reset();

        // Empty display: axis beats grid at x=0, grid, black, range and req gating.
        pix(0, 239);
        pix(64, 10);
        pix(5, 10);
        pix(700, 10);
        pix(100, 479);
        pix(100, 480);
        pix_req(0, 239, 1'b0);
        random_pixels(8);

        // Ramp through the zero level; the 130 sample triggers.
        send(100, 0); send(110, 0); send(120, 0); send(130, 0); send(140, 0);
        while (win_n < 640) send((win_n == 639) ? 200 : int'($urandom_range(0, 255)), 0);
        send(55, 0);
        send(56, 0);
        pix(0, 237);
        frame();
        pix(0, 237);
        pix(1, 227);
        random_pixels(20);

        // Constant 200: no crossing, so capture is forced by the timeout.
        seen = 0;
        while (win_n < 640) begin
            send(200, (win_n == 300) || (win_n == 639));
            if (win_n == 301 && !seen) begin
                seen = 1;
                pix(0, 237);
            end
        end
        send(200, 0);
        pix(0, 237);
        pix(5, 167);
        frame();
        for (int j = 0; j < 8; j++) pix($urandom_range(0, 639), 167);
        pix(0, 237);
        pix(639, 167);

        // Reset in the middle of a capture, then a fresh capture.
        while (win_n < 300) send($urandom_range(0, 255), 0);
        do_reset();
        pix(0, 239);
        random_pixels(6);
        while (win_n < 640) send($urandom_range(0, 255), 0);
        send(9, 0);
        frame();
        random_pixels(20);

        // Decimation by 4 on the second instance.
        sel = 1'b1;
        cur_decim = 4;
        do_reset();
        while (win_n < 640) send($urandom_range(0, 255), 0);
        send(9, 0);
        frame();
        for (int j = 0; j < 24; j++) begin
            int x = $urandom_range(0, 639);
            pix(x, 367 - disp[x]);
        end
        random_pixels(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
